fifo_rd_stream_adapter: RTL

//  Sits directly downstream of the synchronous FIFO and drains it through the FIFO read port
//  (r_en, empty, registered data_out with 1-cycle read latency). Presents the data as a

---
 rtl/fifo_pkg.sv | 13 +
 rtl/fifo_rd_stream_adapter_if.sv | 25 ++
 rtl/fifo_rd_buf.sv | 58 +++++
 rtl/fifo_rd_stream_adapter.sv | 69 ++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter: default widths
// and a clog2 helper that never returns a zero-width result.
package fifo_pkg;

    localparam int FIFO_WIDTH      = 8;
    localparam int PKT_LEN_DEFAULT = 4;

    // Pointer and counter widths must stay at least 1 bit even for 1- or 2-entry ranges.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream.
// The master modport is the adapter side.
interface fifo_rd_stream_adapter_if #(
    parameter int WIDTH = fifo_pkg::FIFO_WIDTH
);

    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_r_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_r_en, m_valid, m_data, m_last
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_r_en, m_valid, m_data, m_last
    );

endinterface

// File: rtl/fifo_rd_buf.sv
// Small circular buffer holding prefetched FIFO words; push and pop may
// happen in the same cycle, in which case occupancy is unchanged.
module fifo_rd_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic [WIDTH-1:0]             head_data
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage is never reset: contents are only observed once occ says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Drains a synchronous FIFO (1-cycle read latency) into a framed valid/ready
// stream, prefetching into a local buffer to sustain one beat per clock.
module fifo_rd_stream_adapter
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_WIDTH,
    parameter int BUF_DEPTH = 3,
    parameter int PKT_LEN   = PKT_LEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    output logic                       busy,
    fifo_rd_stream_adapter_if.master   bus
);

    localparam int OCC_W = $clog2(BUF_DEPTH+1);
    localparam int CNT_W = clog2_min1(PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_LEN-1);

    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic [WIDTH-1:0] head_data;
    logic [CNT_W-1:0] beat_cnt;
    logic             has_room;
    logic             xfer;

    // Counting in-flight reads against capacity guarantees every capture has a free slot.
    assign has_room      = (int'(occ) + int'(inflight)) < BUF_DEPTH;
    assign bus.fifo_r_en = reset & en & ~bus.fifo_empty & has_room;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_r_en;
        end
    end

    // Read-data stage: the FIFO word arrives one cycle after the issue and is pushed here.
    fifo_rd_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (bus.fifo_data),
        .pop       (xfer),
        .occ       (occ),
        .head_data (head_data)
    );

    assign bus.m_valid = (occ != '0);
    assign bus.m_data  = bus.m_valid ? head_data : '0;
    assign bus.m_last  = (beat_cnt == LAST_BEAT);
    assign xfer        = bus.m_valid & bus.m_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beat_cnt <= '0;
        end else if (xfer) begin
            beat_cnt <= bus.m_last ? '0 : beat_cnt + CNT_W'(1);
        end
    end

    assign busy = bus.m_valid | inflight;

endmodule
